// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int DEF_WIDTH  = 13;
  localparam int DEF_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Largest value representable in the given number of BCD digits.
  function automatic int calc_maxv(input int digits);
    int p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return p - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter; the result register only updates on
// completion so downstream display logic never sees a partial conversion.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_bin,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_overflow
);

  localparam int MAXV = calc_maxv(DIGITS);
  localparam int BW   = 4 * DIGITS;
  localparam int WW   = BW + WIDTH;
  localparam int CW   = $clog2(WIDTH);
  localparam int MW   = $clog2(MAXV + 1);
  localparam int WP   = (WIDTH > MW) ? WIDTH : MW;

  localparam logic [WP-1:0]    MAXV_WP = WP'(MAXV);
  localparam logic [WIDTH-1:0] MAXV_B  = WIDTH'(MAXV);

  state_t             r_state;
  state_t             w_next_state;
  logic [CW-1:0]      r_cnt;
  logic [WW-1:0]      r_work;
  logic [BW-1:0]      r_bcd;
  logic               r_ovf;
  logic               r_ovf_pend;
  logic [BW-1:0]      w_adj;
  logic [WW-1:0]      w_shifted;
  logic [WIDTH-1:0]   w_bin_clamped;
  logic               w_ovf_in;
  logic               w_accept;
  logic               w_last;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_digit (r_work[WIDTH + 4*g +: 4]),
        .o_digit (w_adj[4*g +: 4])
      );
    end
  endgenerate

  // Compare at a width wide enough for both the input and MAXV.
  assign w_ovf_in      = WP'(i_bin) > MAXV_WP;
  assign w_bin_clamped = w_ovf_in ? MAXV_B : i_bin;
  assign w_shifted     = {w_adj, r_work[WIDTH-1:0]} << 1;

  assign o_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign o_busy   = (r_state == ST_SHIFT);
  assign o_done   = (r_state == ST_DONE);
  assign w_accept = o_ready && i_start;
  assign w_last   = (r_state == ST_SHIFT) && (r_cnt == CW'(WIDTH - 1));

  assign o_bcd      = r_bcd;
  assign o_overflow = r_ovf;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_last)  w_next_state = ST_DONE;
      ST_DONE:  w_next_state = i_start ? ST_SHIFT : ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_work     <= '0;
      r_cnt      <= '0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_ovf_pend <= 1'b0;
    end else if (w_accept) begin
      r_work     <= {{BW{1'b0}}, w_bin_clamped};
      r_ovf_pend <= w_ovf_in;
      r_cnt      <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_work <= w_shifted;
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        r_bcd <= w_shifted[WW-1 -: BW];
        r_ovf <= r_ovf_pend;
      end
    end
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential double-dabble binary-to-BCD converter sitting directly upstream of the seven-segment display driver. It converts a binary value (PC low bits, register value, cycle count) into packed 4-digit BCD over a fixed number of cycles. The display stage can then select digits instead of performing per-digit division and modulo. The result register updates only on completion, so the display never sees a partially converted value.

## Interface
- WIDTH, 13, binary input width (≥4)
- DIGITS, 4, BCD output digits; max representable value MAXV = 10^DIGITS − 1
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request conversion; sampled only when ready
- bin  in  WIDTH  unsigned binary value, sampled with accepted start
- ready  out  1  high in IDLE and DONE; start accepted when ready & start
- busy  out  1  high while converting (SHIFT state)
- done  out  1  one-cycle pulse: bcd/overflow just updated
- bcd  out  4·DIGITS  packed BCD, digit 0 (ones) in [3:0]; holds last result
- overflow  out  1  last accepted bin exceeded MAXV; result clamped

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE/DONE + start:
  - load the working register {bcd_work (4·DIGITS bits, zero), bin_work (WIDTH)} with bin_work = min(bin, MAXV);
  - latch ovf_pend = (bin > MAXV);
  - cnt = 0; go to SHIFT.
- DONE without start → IDLE.
- SHIFT, each cycle:
  - every BCD digit ≥5 gets +3 (4-bit add, no carry out);
  - then shift the whole working register left 1;
  - cnt increments.
  - When cnt == WIDTH−1, the shift in that cycle is the last; go to DONE.
- Entry to DONE: bcd ← bcd_work after final shift; overflow ← ovf_pend; done = 1 for exactly that cycle.
- start while busy is ignored; no queueing.
- bcd and overflow change only at DONE entry; otherwise hold.
- Counter width: clog2(WIDTH). Working register width: 4·DIGITS + WIDTH.
- Comparison bin > MAXV is done at WIDTH' = max(WIDTH, clog2(MAXV+1)) bits. With defaults (8191 < 9999) overflow is always 0.

## Timing
- Reset (async assert, sync release): state IDLE, ready 1, busy 0, done 0, bcd 0, overflow 0, cnt 0, working register 0.
- Start accepted at edge k:
  - busy high after k;
  - WIDTH shift edges k+1 … k+WIDTH;
  - done and new bcd visible after edge k+WIDTH (13 cycles, default).
- done low after edge k+WIDTH+1 unless a new conversion completes.
- Back-to-back: start held high in DONE is accepted at edge k+WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- ready is combinational from state: 1 in IDLE/DONE, 0 in SHIFT.
- Reset mid-conversion:
  - abort immediately;
  - bcd returns to 0;
  - no done pulse;
  - start the cycle after reset release is accepted normally.

## Structure
- Shared package `bin2bcd_pkg`:
  - state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - default WIDTH/DIGITS constants;
  - function computing MAXV from DIGITS.
- Sub-module `bcd_digit_adj`: combinational 4-bit "add 3 if ≥5", instantiated DIGITS times via generate.
- Top: FSM, counter, working register, result/overflow registers.

## Test plan
- Reset, then start with bin=1234 → busy for 13 cycles; done pulses at cycle 13; bcd=16'h1234; overflow=0; ready back to 1.
- bin=0, then bin=8191 back-to-back (start held high) → bcd=16'h0000 at cycle 13, bcd=16'h8191 at cycle 27; single done pulse each.
- Start at cycle 5 of a 4321 conversion with bin=99 → ignored; bcd=16'h4321; exactly one done pulse.
- WIDTH=14 instance, bin=16383 → bcd=16'h9999, overflow=1 after 14 cycles; next bin=9999 → bcd=16'h9999, overflow=0.
- Assert rst at cycle 6 of a 5678 conversion → bcd=0, busy=0, no done pulse. Start 7 after release → bcd=16'h0007 13 cycles later.
- Random bin 0–8191, 1000 conversions → bcd digits match bin/1000, bin%1000/100, bin%100/10, bin%10; bcd stable between done pulses.
